// File: rtl/mem_bus_target.sv
// rtl/mem_bus_target.sv - CPU bus responder: word RAM at 0, MMIO page with TX byte FIFO and cycle counter.
// Define MEM_BUS_TIMER_EN to add the TIMER_CMP/TIMER_CTRL compare-interrupt registers.
module mem_bus_target #(
  parameter int          RAM_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFFF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_wdata,
  input  logic        bus_rw,
  output logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int          RAM_AW     = $clog2(RAM_WORDS);
  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [9:0] REG_TXDATA     = 10'd0;
  localparam logic [9:0] REG_STATUS     = 10'd1;
  localparam logic [9:0] REG_CYCLES     = 10'd2;
  localparam logic [9:0] REG_TIMER_CMP  = 10'd3;
  localparam logic [9:0] REG_TIMER_CTRL = 10'd4;

  logic [31:0]       ram [RAM_WORDS];
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic              overflow;
  logic [31:0]       cycles;

  logic              is_ram;
  logic              is_mmio;
  logic [9:0]        reg_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en;
  logic              mmio_wr;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic [31:0]       status_word;

  // RAM wins the decode should a configuration ever overlap the MMIO page.
  assign is_ram   = bus_address < RAM_BYTES;
  assign is_mmio  = !is_ram && (bus_address[31:12] == MMIO_BASE[31:12]);
  assign reg_idx  = bus_address[11:2];
  assign ram_idx  = bus_address[RAM_AW+1:2];
  assign wr_en    = bus_rw && !reset;
  assign mmio_wr  = wr_en && is_mmio;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop      = !empty && tx_ready;
  assign push_req = mmio_wr && (reg_idx == REG_TXDATA);
  assign push_ok  = push_req && (!full || pop);

  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  assign status_word = {20'd0, 4'(count), 5'd0, overflow, empty, full};

  always_ff @(posedge clk) begin
    if (wr_en && is_ram) begin
      ram[ram_idx] <= bus_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cycles   <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count + (PW + 1)'(push_ok) - (PW + 1)'(pop);
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (mmio_wr && (reg_idx == REG_STATUS) && bus_wdata[2]) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef MEM_BUS_TIMER_EN
  logic [31:0] timer_cmp;
  logic        timer_en;
  logic        timer_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_cmp  <= '0;
      timer_en   <= 1'b0;
      timer_pend <= 1'b0;
    end else begin
      if (mmio_wr && (reg_idx == REG_TIMER_CMP)) begin
        timer_cmp <= bus_wdata;
      end
      if (mmio_wr && (reg_idx == REG_TIMER_CTRL)) begin
        timer_en <= bus_wdata[0];
      end
      // A compare hit in the same cycle as a W1C keeps pending set.
      if (timer_en && (cycles == timer_cmp)) begin
        timer_pend <= 1'b1;
      end else if (mmio_wr && (reg_idx == REG_TIMER_CTRL) && bus_wdata[1]) begin
        timer_pend <= 1'b0;
      end
    end
  end

  assign irq = timer_pend;
`else
  assign irq = 1'b0;
`endif

  // Combinational read: the CPU samples bus_rdata one edge after driving the address.
  always_comb begin
    bus_rdata = '0;
    if (is_ram) begin
      bus_rdata = ram[ram_idx];
    end else if (is_mmio) begin
      case (reg_idx)
        REG_STATUS:     bus_rdata = status_word;
        REG_CYCLES:     bus_rdata = cycles;
`ifdef MEM_BUS_TIMER_EN
        REG_TIMER_CMP:  bus_rdata = timer_cmp;
        REG_TIMER_CTRL: bus_rdata = {30'd0, timer_pend, timer_en};
`endif
        default:        bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_target.sv
// tb/tb_mem_bus_target.sv - scoreboard bench for mem_bus_target against a queue-based reference model.
module tb_mem_bus_target;

  localparam int          RAM_WORDS  = 4096;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFFF000;
  localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [31:0] A_TX   = MMIO_BASE;
  localparam logic [31:0] A_ST   = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_CY   = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_CMP  = MMIO_BASE + 32'hC;
  localparam logic [31:0] A_CTRL = MMIO_BASE + 32'h10;

  logic        clk;
  logic        reset;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;
  logic        bus_rw;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  mem_bus_target #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_address(bus_address),
    .bus_wdata  (bus_wdata),
    .bus_rw     (bus_rw),
    .bus_rdata  (bus_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state
  logic [31:0] m_ram [int unsigned];
  logic [7:0]  m_fifo [$];
  logic [7:0]  exp_tx [$];
  bit          m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] m_cmp;
  bit          m_ten;
  bit          m_pend;
  bit          set_p;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;
  rd_t rd_q [$];
  rd_t cur_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    n = m_fifo.size();
    if (a < RAM_BYTES) return m_ram.exists(a[31:2]) ? m_ram[a[31:2]] : 32'h0;
    if (a[31:12] != MMIO_BASE[31:12]) return 32'h0;
    case (a[11:2])
      10'd1: return {20'd0, 4'(n), 5'd0, m_ovf, n == 0, n == FIFO_DEPTH};
      10'd2: return m_cyc;
`ifdef MEM_BUS_TIMER_EN
      10'd3: return m_cmp;
      10'd4: return {30'd0, m_pend, m_ten};
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Model advances on every clock edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (reset) begin
      m_fifo.delete();
      exp_tx.delete();
      m_ovf  = 1'b0;
      m_cyc  = 32'h0;
      m_cmp  = 32'h0;
      m_ten  = 1'b0;
      m_pend = 1'b0;
    end else begin
      set_p = m_ten && (m_cyc == m_cmp);
      if (m_fifo.size() != 0 && tx_ready) void'(m_fifo.pop_front());
      if (bus_rw) begin
        if (bus_address < RAM_BYTES) begin
          m_ram[bus_address[31:2]] = bus_wdata;
        end else if (bus_address[31:12] == MMIO_BASE[31:12]) begin
          case (bus_address[11:2])
            10'd0: begin
              if (m_fifo.size() < FIFO_DEPTH) begin
                m_fifo.push_back(bus_wdata[7:0]);
                exp_tx.push_back(bus_wdata[7:0]);
              end else begin
                m_ovf = 1'b1;
              end
            end
            10'd1: if (bus_wdata[2]) m_ovf = 1'b0;
`ifdef MEM_BUS_TIMER_EN
            10'd3: m_cmp = bus_wdata;
            10'd4: begin
              m_ten = bus_wdata[0];
              if (bus_wdata[1]) m_pend = 1'b0;
            end
`endif
            default: ;
          endcase
        end
      end
      if (set_p) m_pend = 1'b1;
      m_cyc = m_cyc + 32'd1;
    end
  end

  // Monitor: samples mid-cycle, after inputs settle and before the next edge.
  always begin
    @(negedge clk);
    #3;
    if (mon_en) begin
      check("tx_valid", {31'd0, tx_valid}, {31'd0, m_fifo.size() != 0});
`ifdef MEM_BUS_TIMER_EN
      check("irq", {31'd0, irq}, {31'd0, m_pend});
`else
      check("irq", {31'd0, irq}, 32'h0);
`endif
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_data: got %h expected no byte", tx_data);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        end
      end
      if (rd_q.size() != 0) begin
        cur_rd = rd_q.pop_front();
        check(cur_rd.name, bus_rdata, cur_rd.val);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    bus_address = a;
    bus_wdata   = d;
    bus_rw      = 1'b1;
    @(posedge clk);
    #1;
    bus_rw = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input string n);
    @(negedge clk);
    #1;
    bus_address = a;
    bus_rw      = 1'b0;
    rd_q.push_back('{name: n, val: model_read(a)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned w;
    reset       = 1'b1;
    bus_address = '0;
    bus_wdata   = '0;
    bus_rw      = 1'b0;
    tx_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    rd(A_ST, "status_reset");
    rd(A_CY, "cycles_reset");

    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, "ram_read");
    rd(32'h13, "ram_read_low_bits");
    rd(RAM_BYTES, "unmapped_read");
    rd(A_TX, "txdata_read");
    rd(MMIO_BASE + 32'h20, "mmio_unassigned");

    for (int i = 0; i < 8; i++) wr(A_TX, 32'h41 + i);
    rd(A_ST, "status_full");
    wr(A_TX, 32'h49);
    rd(A_ST, "status_overflow");
    wr(A_ST, 32'h4);
    rd(A_ST, "status_overflow_clr");

    @(negedge clk);
    #1;
    tx_ready    = 1'b1;
    bus_address = A_TX;
    bus_wdata   = 32'h50;
    bus_rw      = 1'b1;
    @(posedge clk);
    #1;
    bus_rw   = 1'b0;
    tx_ready = 1'b0;
    rd(A_ST, "status_full_push_pop");

    @(negedge clk);
    #1;
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    rd(A_ST, "status_drained");

    rd(A_CY, "cycles_a");
    repeat (4) @(negedge clk);
    rd(A_CY, "cycles_b");

    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h60 + i);
    @(negedge clk);
    #1;
    tx_ready = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset       = 1'b0;
    bus_address = A_CY;
    rd_q.push_back('{name: "cycles_after_reset", val: model_read(A_CY)});
    rd(A_ST, "status_after_reset");

    wr(A_CMP, 32'd20);
    wr(A_CTRL, 32'd1);
    repeat (25) @(negedge clk);
    rd(A_CTRL, "timer_ctrl_pending");
    wr(A_CTRL, 32'd3);
    rd(A_CTRL, "timer_ctrl_cleared");
    rd(A_CMP, "timer_cmp");

    tx_ready = 1'b0;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 8))
        0: wr({$urandom_range(0, 15), 2'($urandom_range(0, 3))}, $urandom);
        1: begin
          w = $urandom_range(0, 15);
          if (m_ram.exists(w)) rd({w[29:0], 2'($urandom_range(0, 3))}, "ram_random");
          else wr({w[29:0], 2'b00}, $urandom);
        end
        2, 3: wr(A_TX, $urandom);
        4: rd(A_ST, "status_random");
        5: rd(A_CY, "cycles_random");
        6: wr(A_ST, $urandom);
        7: begin
          @(negedge clk);
          #1;
          tx_ready = 1'($urandom_range(0, 1));
        end
        default: rd(32'h0001_0000 + ($urandom & 32'h0000_FFFC), "unmapped_random");
      endcase
    end

    @(negedge clk);
    #1;
    tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    rd(A_ST, "status_final");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
